// File: rtl/fpu_align_pkg.sv
// Shared types and default sizes for the FPU operand alignment controller.
// Imported by fpu_align_ctrl and fpu_align_step.
package fpu_align_pkg;

  localparam int SIZE_MAN_DEF = 24;
  localparam int SIZE_EXP_DEF = 8;
  localparam int MAX_STEP_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/fpu_align_step.sv
// One bounded right-shift step of the small mantissa (0..MAX_STEP bits).
// With FPU_ALIGN_STICKY_EN it also flags any nonzero bit shifted out.
module fpu_align_step
  import fpu_align_pkg::*;
#(
  parameter  int SIZE_MAN = SIZE_MAN_DEF,
  parameter  int MAX_STEP = MAX_STEP_DEF,
  localparam int SW       = $clog2(MAX_STEP + 1)
) (
  input  logic [SIZE_MAN-1:0] i_man,
  input  logic [SW-1:0]       i_amt,
`ifdef FPU_ALIGN_STICKY_EN
  output logic                o_lost,
`endif
  output logic [SIZE_MAN-1:0] o_man
);

  // shift; dropped bits are nonzero iff shifting back fails to restore
  always_comb begin
    o_man = i_man >> i_amt;
`ifdef FPU_ALIGN_STICKY_EN
    o_lost = ((o_man << i_amt) != i_man);
`endif
  end

endmodule

// File: rtl/fpu_align_ctrl.sv
// Exponent compare and multi-cycle mantissa alignment with handshakes.
// Optional sticky tracking is enabled by FPU_ALIGN_STICKY_EN.
module fpu_align_ctrl
  import fpu_align_pkg::*;
#(
  parameter int SIZE_MAN = SIZE_MAN_DEF,
  parameter int SIZE_EXP = SIZE_EXP_DEF,
  parameter int MAX_STEP = MAX_STEP_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [SIZE_EXP-1:0] i_exp_a,
  input  logic [SIZE_EXP-1:0] i_exp_b,
  input  logic [SIZE_MAN-1:0] i_man_a,
  input  logic [SIZE_MAN-1:0] i_man_b,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SIZE_EXP-1:0] o_exp,
  output logic [SIZE_MAN-1:0] o_man_big,
  output logic [SIZE_MAN-1:0] o_man_small,
  output logic                o_sticky,
  output logic                o_swap
);

  localparam int SW = $clog2(MAX_STEP + 1);

  state_e              state_q, state_d;
  logic                swap_q, swap_d;
  logic [SIZE_EXP-1:0] exp_q, exp_d;
  logic [SIZE_MAN-1:0] big_q, big_d;
  logic [SIZE_MAN-1:0] small_q, small_d;
  logic [SIZE_EXP-1:0] rem_q, rem_d;

  logic                swap_in;
  logic [SIZE_EXP-1:0] diff;
  logic [SIZE_MAN-1:0] small_in;
  logic                sat;
  logic [SW-1:0]       amt;
  logic [SIZE_MAN-1:0] step_man;
`ifdef FPU_ALIGN_STICKY_EN
  logic                step_lost;
`endif

  // order operands of a new request and measure their distance
  always_comb begin
    swap_in  = i_exp_b > i_exp_a;
    diff     = swap_in ? i_exp_b - i_exp_a : i_exp_a - i_exp_b;
    small_in = swap_in ? i_man_a : i_man_b;
    sat      = 32'(diff) >= SIZE_MAN;
    amt      = (32'(rem_q) > MAX_STEP) ? SW'(MAX_STEP) : SW'(rem_q);
  end

  fpu_align_step #(
    .SIZE_MAN (SIZE_MAN),
    .MAX_STEP (MAX_STEP)
  ) u_step (
    .i_man  (small_q),
    .i_amt  (amt),
`ifdef FPU_ALIGN_STICKY_EN
    .o_lost (step_lost),
`endif
    .o_man  (step_man)
  );

  // next state and datapath update
  always_comb begin
    state_d = state_q;
    swap_d  = swap_q;
    exp_d   = exp_q;
    big_d   = big_q;
    small_d = small_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          swap_d  = swap_in;
          exp_d   = swap_in ? i_exp_b : i_exp_a;
          big_d   = swap_in ? i_man_b : i_man_a;
          small_d = small_in;
          rem_d   = '0;
          state_d = DONE;
          if (sat) begin
            small_d = '0;
          end else if (diff != '0) begin
            rem_d   = diff;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        small_d = step_man;
        rem_d   = rem_q - SIZE_EXP'(amt);
        if (rem_d == '0) state_d = DONE;
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      swap_q  <= 1'b0;
      exp_q   <= '0;
      big_q   <= '0;
      small_q <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      swap_q  <= swap_d;
      exp_q   <= exp_d;
      big_q   <= big_d;
      small_q <= small_d;
      rem_q   <= rem_d;
    end
  end

`ifdef FPU_ALIGN_STICKY_EN
  logic sticky_q, sticky_d;

  // collect every nonzero bit dropped from the small mantissa
  always_comb begin
    sticky_d = sticky_q;
    unique case (state_q)
      IDLE:    if (i_valid) sticky_d = sat ? |small_in : 1'b0;
      SHIFT:   sticky_d = sticky_q | step_lost;
      default: sticky_d = sticky_q;
    endcase
  end

  // sticky register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sticky_q <= 1'b0;
    else          sticky_q <= sticky_d;
  end

  assign o_sticky = sticky_q;
`else
  assign o_sticky = 1'b0;
`endif

  assign o_ready     = (state_q == IDLE);
  assign o_valid     = (state_q == DONE);
  assign o_swap      = swap_q;
  assign o_exp       = exp_q;
  assign o_man_big   = big_q;
  assign o_man_small = small_q;

endmodule

// File: doc/fpu_align_ctrl.md
FPU_ALIGN_CTRL -- requirements
Module: fpu_align_ctrl

Interface
REQ-001 SHALL have parameter SIZE_MAN, default 24, meaning mantissa width including hidden bit.
REQ-002 SHALL have parameter SIZE_EXP, default 8, meaning exponent width.
REQ-003 SHALL have parameter MAX_STEP, default 8, meaning maximum right-shift distance applied per cycle (1..SIZE_MAN).
REQ-004 SHALL have ports: i_clk in 1 clock; i_rst_n in 1 asynchronous active-low reset (one clock, async active-low reset, fixed).
REQ-005 SHALL have ports: i_valid in 1 operand valid; o_ready out 1 operand accept; i_exp_a, i_exp_b in SIZE_EXP exponents; i_man_a, i_man_b in SIZE_MAN mantissas.
REQ-006 SHALL have ports: o_valid out 1 result valid; i_ready in 1 downstream accept; o_exp out SIZE_EXP larger exponent; o_man_big out SIZE_MAN unshifted mantissa; o_man_small out SIZE_MAN aligned mantissa; o_sticky out 1 OR of shifted-out bits; o_swap out 1 operand B was larger.

Function
REQ-007 SHALL implement FSM states IDLE, SHIFT, DONE.
REQ-008 SHALL assert o_ready only in IDLE; transfer occurs on i_valid && o_ready at a rising edge.
REQ-009 SHALL on transfer set swap = (i_exp_b > i_exp_a); equal exponents give swap=0; latch big/small operands accordingly and diff = |i_exp_a - i_exp_b|.
REQ-010 SHALL on transfer go to DONE directly when diff==0 (no shift) or diff>=SIZE_MAN (saturate: man_small=0, sticky=OR of all small-mantissa bits); otherwise go to SHIFT with remaining=diff.
REQ-011 SHALL in each SHIFT cycle right-shift man_small by min(remaining, MAX_STEP), OR the shifted-out bits into sticky, decrement remaining; go to DONE when remaining reaches 0.
REQ-012 SHALL give latency from transfer edge to o_valid high of 1 cycle for diff==0 or saturated, else 1+ceil(diff/MAX_STEP).
REQ-013 SHALL assert o_valid only in DONE; hold all outputs stable while o_valid && !i_ready.
REQ-014 SHALL return to IDLE on o_valid && i_ready; no same-cycle new accept (one bubble between operations).
REQ-015 SHALL ignore i_valid and input changes outside IDLE.
REQ-016 SHALL keep o_exp equal to the larger exponent, o_man_big unshifted.

Reset
REQ-017 SHALL on i_rst_n low immediately enter IDLE and clear o_valid, o_sticky, o_swap, o_exp, o_man_big, o_man_small, remaining to 0; o_ready high after reset.
REQ-018 SHALL discard any in-flight operation on reset with no o_valid pulse after release.

Configuration
REQ-019 SHALL with macro FPU_ALIGN_STICKY_EN defined compute o_sticky per REQ-010/011.
REQ-020 SHALL without FPU_ALIGN_STICKY_EN tie o_sticky to 0 and omit sticky logic; all other behaviour and latency unchanged.

Structure
REQ-021 SHALL place state enum and default SIZE_MAN/SIZE_EXP/MAX_STEP constants in shared package fpu_align_pkg.
REQ-022 SHALL implement per-cycle bounded shift plus sticky extraction in sub-module fpu_align_step (combinational, shift amount 0..MAX_STEP).

Verification (defaults)
REQ-023 exp_a=0x85, exp_b=0x80, man_a=0x800000, man_b=0xC00000 -> latency 2, o_exp=0x85, o_swap=0, o_man_big=0x800000, o_man_small=0x060000, o_sticky=0.
REQ-024 exp_a=0x80, exp_b=0x94, man_a=0x800001, man_b=0x900000 -> latency 4 (shifts 8,8,4), o_swap=1, o_exp=0x94, o_man_big=0x900000, o_man_small=0x000008, o_sticky=1 (0 without macro).
REQ-025 exp_a=0x9E, exp_b=0x80, man_b=0x000001 -> saturated, latency 1, o_man_small=0, o_sticky=1; equal exponents 0x7F -> latency 1, o_swap=0, mantissas unchanged.
REQ-026 i_ready held low 3 cycles in DONE -> o_valid and outputs stable, o_ready low; i_ready high -> IDLE next cycle, o_ready high.
REQ-027 i_rst_n pulsed low during second SHIFT cycle of REQ-024 -> all outputs 0 immediately, o_ready high after release, no o_valid; next operation completes correctly.
